unary_add_sequencer: RTL and testbench

//  Upstream stage of the 1..7-bit unary adder. Accepts two binary operands over a

---
 rtl/unary_add_pkg.sv | 26 ++
 rtl/unary_stream_gen.sv | 44 ++++
 rtl/unary_add_sequencer.sv | 161 ++++++++++++++++
 tb/tb_unary_add_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_add_pkg.sv
// -----------------------------------------------------------------------------
// unary_add_pkg
//   Shared constants for the unary adder sequencer and its stream generators.
//   UA_W       default operand/sum width (paired adder counter width)
//   ST_*       sequencer FSM state encodings
//   write_max  drain-length guard: longest legal WRITE phase plus one
// -----------------------------------------------------------------------------
package unary_add_pkg;

    localparam int UA_W = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A full drain of a W-bit adder takes 2^W cycles of dout plus the cycle
    // that absorbs the registered C, so 2^W+1 can only be reached if the
    // adder misbehaves.
    function automatic int write_max(input int w);
        return (1 << w) + 1;
    endfunction

    localparam int WRITE_MAX = (1 << UA_W) + 1;

endpackage

// File: rtl/unary_stream_gen.sv
// -----------------------------------------------------------------------------
// unary_stream_gen
//   Converts a binary value into a unary pulse train: loads a W-bit counter,
//   then emits one '1' per decrement until the counter is empty.
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (counter -> 0)
//   load      in   capture load_val into the counter (wins over dec)
//   load_val  in   W  value to serialise
//   dec       in   decrement the counter this cycle if nonzero
//   strm      out  unary stream bit (count != 0); low doubles as the zero flag
//   last      out  count <= 1, i.e. the counter is empty after this decrement
// -----------------------------------------------------------------------------
module unary_stream_gen
    import unary_add_pkg::*;
#(
    parameter int W = UA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         strm,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign strm = (count != '0);
    // Upper bits clear means the value is 0 or 1.
    assign last = (count[W-1:1] == '0);

endmodule

// File: rtl/unary_add_sequencer.sv
// -----------------------------------------------------------------------------
// unary_add_sequencer
//   Front end for the W-bit unary adder. Takes a binary operand pair over a
//   valid/ready handshake, streams both operands into the adder in unary form
//   (READ), then drains the adder (WRITE), counting dout ones to rebuild the
//   binary sum. Any adder carry C seen during the operation sets ovf.
//   The result is offered over a second valid/ready handshake (DONE).
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset (shared with the adder)
//   in_valid       in   operand pair valid
//   in_ready       out  high in IDLE only
//   a_val, b_val   in   W  binary operands
//   A, B           out  unary streams to the adder
//   en             out  adder enable (READ or WRITE)
//   read_or_write  out  0 = accumulate, 1 = drain
//   dout           in   adder drain stream
//   C              in   adder overflow strobe (registered in the adder)
//   res_valid      out  result available (DONE)
//   res_ready      in   result consumed
//   sum            out  W  (a+b) mod 2^W
//   ovf            out  any carry seen during the operation
// -----------------------------------------------------------------------------
module unary_add_sequencer
    import unary_add_pkg::*;
#(
    parameter int W = UA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_val,
    input  logic [W-1:0] b_val,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    input  logic         dout,
    input  logic         C,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam int         WMAX_I   = write_max(W);
    localparam logic [W:0] WCNT_MAX = WMAX_I[W:0];

    logic [1:0]   state;
    logic [W-1:0] ones;
    logic [W:0]   wcnt;
    logic [W-1:0] sum_r;
    logic         ovf_r;
    logic         first_rd;

    logic accept;
    logic in_read;
    logic in_write;
    logic a_strm, a_last;
    logic b_strm, b_last;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign in_read  = (state == ST_READ);
    assign in_write = (state == ST_WRITE);

    unary_stream_gen #(.W(W)) u_gen_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (a_val),
        .dec      (in_read),
        .strm     (a_strm),
        .last     (a_last)
    );

    unary_stream_gen #(.W(W)) u_gen_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (b_val),
        .dec      (in_read),
        .strm     (b_strm),
        .last     (b_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ones     <= '0;
            wcnt     <= '0;
            sum_r    <= '0;
            ovf_r    <= 1'b0;
            first_rd <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ovf_r    <= 1'b0;
                        ones     <= '0;
                        wcnt     <= '0;
                        first_rd <= 1'b1;
                        // Nothing to stream for a zero pair: go straight to the drain.
                        state    <= ((a_val | b_val) != '0) ? ST_READ : ST_WRITE;
                    end
                end

                ST_READ: begin
                    first_rd <= 1'b0;
                    // C lags the adder by one cycle, so the first READ cycle
                    // still shows whatever preceded this operation.
                    if (!first_rd) begin
                        ovf_r <= ovf_r | C;
                    end
                    if (a_last && b_last) begin
                        state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == '0) begin
                        // Carry from the final READ cycle lands here; dout is
                        // not yet valid because the adder registers it.
                        ovf_r <= ovf_r | C;
                    end else if (wcnt == WCNT_MAX) begin
                        // Adder never reported empty: abort and flag it.
                        sum_r <= ones;
                        ovf_r <= 1'b1;
                        state <= ST_DONE;
                    end else if (!dout) begin
                        sum_r <= ones;
                        state <= ST_DONE;
                    end else begin
                        ones <= ones + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state == ST_IDLE);
    assign res_valid     = (state == ST_DONE);
    assign A             = in_read && a_strm;
    assign B             = in_read && b_strm;
    assign en            = in_read || in_write;
    assign read_or_write = in_write;
    assign sum           = sum_r;
    assign ovf           = ovf_r;

endmodule

// File: tb/tb_unary_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_unary_add_sequencer
//   Pairs the sequencer with a behavioural W=7 unary adder and checks every
//   cycle against an operation schedule derived from the operand values:
//   max(a,b) READ cycles, (a+b mod 128)+2 WRITE cycles, then DONE.
// -----------------------------------------------------------------------------
module tb_unary_add_sequencer;

    localparam int W   = 7;
    localparam int MOD = 128;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] a_val     = '0;
    logic [W-1:0] b_val     = '0;
    logic         in_ready;
    logic         A, B, en, read_or_write;
    logic         dout, C;
    logic         res_valid;
    logic [W-1:0] sum;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;

    unary_add_sequencer #(.W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_val         (a_val),
        .b_val         (b_val),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .sum           (sum),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- paired unary adder (behavioural) ----------------
    logic [W-1:0] add_cnt;
    logic [W:0]   add_next;
    assign add_next = {1'b0, add_cnt} + {{W{1'b0}}, A} + {{W{1'b0}}, B};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_cnt <= '0;
            C       <= 1'b0;
            dout    <= 1'b0;
        end else if (en && !read_or_write) begin
            add_cnt <= add_next[W-1:0];
            C       <= add_next[W];
            dout    <= 1'b0;
        end else if (en && read_or_write) begin
            C <= 1'b0;
            if (add_cnt != '0) begin
                dout    <= 1'b1;
                add_cnt <= add_cnt - 1'b1;
            end else begin
                dout <= 1'b0;
            end
        end else begin
            C    <= 1'b0;
            dout <= 1'b0;
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: operation schedule ----------------
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_t    = 0;
    int   m_a    = 0;
    int   m_b    = 0;
    int   m_len  = 0;
    int   m_sum  = 0;
    int   m_ovf  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_a    <= int'(a_val);
                m_b    <= int'(b_val);
                m_len  <= ((a_val > b_val) ? int'(a_val) : int'(b_val))
                          + ((int'(a_val) + int'(b_val)) % MOD) + 2;
                m_sum  <= (int'(a_val) + int'(b_val)) % MOD;
                m_ovf  <= ((int'(a_val) + int'(b_val)) >= MOD) ? 1 : 0;
            end
        end else if (m_busy) begin
            if (m_t + 1 == m_len) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
            m_t <= m_t + 1;
        end else if (res_ready) begin
            m_done <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        int  rlen;
        bit  e_read;
        bit  e_write;
        if (rst_n) begin
            rlen    = (m_a > m_b) ? m_a : m_b;
            e_read  = m_busy && (m_t < rlen);
            e_write = m_busy && !e_read;
            chk("in_ready",      int'(in_ready),      int'(!m_busy && !m_done));
            chk("res_valid",     int'(res_valid),     int'(m_done));
            chk("en",            int'(en),            int'(m_busy));
            chk("read_or_write", int'(read_or_write), int'(e_write));
            chk("A",             int'(A),             int'(e_read && (m_t < m_a)));
            chk("B",             int'(B),             int'(e_read && (m_t < m_b)));
            if (m_done) begin
                chk("sum", int'(sum), m_sum);
                chk("ovf", int'(ovf), m_ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input int a, input int b, input int s, input int o,
                         input int lat_exp, input int hold);
        int g;
        int lat;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        in_valid = 1'b1;
        a_val    = a[W-1:0];
        b_val    = b[W-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, lat_exp);
        chk("sum_lit", int'(sum), s);
        chk("ovf_lit", int'(ovf), o);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_val    = W'($urandom_range(0, MOD - 1));
            b_val    = W'($urandom_range(0, MOD - 1));
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_sum",       int'(sum), s);
            chk("hold_ovf",       int'(ovf), o);
            chk("hold_in_ready",  int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready), 1);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_A"},         int'(A), 0);
        chk({tag, "_B"},         int'(B), 0);
        chk({tag, "_en"},        int'(en), 0);
        chk({tag, "_rw"},        int'(read_or_write), 0);
        chk({tag, "_sum"},       int'(sum), 0);
        chk({tag, "_ovf"},       int'(ovf), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, s, o, mx;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed results and latencies.
        do_op(3,   4,   7,   0, 13,  0);
        do_op(0,   0,   0,   0, 2,   0);
        do_op(100, 100, 72,  1, 174, 0);
        do_op(127, 1,   0,   1, 129, 0);
        do_op(127, 0,   127, 0, 256, 10);
        do_op(1,   0,   1,   0, 4,   0);

        // Asynchronous reset in the middle of READ.
        @(negedge clk);
        in_valid = 1'b1;
        a_val    = 7'd50;
        b_val    = 7'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("midread_en", int'(en), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(5, 6, 11, 0, 19, 0);

        // Randomised operands, biased toward the extremes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 0;
                1:       a = MOD - 1;
                default: a = $urandom_range(0, MOD - 1);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 0;
                1:       b = MOD - 1;
                default: b = $urandom_range(0, MOD - 1);
            endcase
            s  = (a + b) % MOD;
            o  = ((a + b) >= MOD) ? 1 : 0;
            mx = (a > b) ? a : b;
            do_op(a, b, s, o, mx + s + 2, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
